// File: rtl/regfile_dump_scanner_pkg.sv
// Shared definitions for the register dump scanner: FSM state encodings,
// default frame header byte and frame length constants for both frame formats.
package regfile_dump_scanner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_PCB  = 3'd2,
    ST_SEL  = 3'd3,
    ST_BYTE = 3'd4,
    ST_CSUM = 3'd5,
    ST_FIN  = 3'd6
  } dump_state_e;

  localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;
  localparam int FRAME_BYTES_BASE = 130;
  localparam int FRAME_BYTES_PC   = 134;

  // Header + optional PC word + 4 bytes per register + checksum.
  function automatic int frame_bytes(input int num_regs, input bit pc_en);
    return 2 + 4 * num_regs + (pc_en ? 4 : 0);
  endfunction

endpackage

// File: rtl/regfile_dump_scanner_byte_shifter.sv
// Byte serialiser: loads a word plus a byte count and presents the MSB byte;
// each shift moves the next byte up. Carries header, PC, register and checksum bytes.
module dump_byte_shifter (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic [1:0]  load_len,
  input  logic        shift,
  output logic [7:0]  byte_out,
  output logic        last
);

  logic [31:0] word_q, word_d;
  logic [1:0]  rem_q, rem_d;

  // Next word/remaining-count selection; load takes priority over shift.
  always_comb begin
    word_d = word_q;
    rem_d  = rem_q;
    if (load) begin
      word_d = load_word;
      rem_d  = load_len;
    end else if (shift) begin
      word_d = {word_q[23:0], 8'h00};
      rem_d  = rem_q - 2'd1;
    end else begin
      word_d = word_q;
      rem_d  = rem_q;
    end
  end

  // Word and remaining-byte registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_q <= 32'h0000_0000;
      rem_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      rem_q  <= rem_d;
    end
  end

  assign byte_out = word_q[31:24];
  assign last     = (rem_q == 2'd0);

endmodule

// File: rtl/regfile_dump_scanner.sv
// Steps reg_sel through x0..x(NUM_REGS-1), captures reg_data and streams a framed,
// XOR-checksummed byte dump over valid/ready. Macro DUMP_PC_HEADER_EN adds the PC word.
module regfile_dump_scanner
  import regfile_dump_scanner_pkg::*;
#(
  parameter int         NUM_REGS      = 32,
  parameter int         SETTLE_CYCLES = 1,
  parameter logic [7:0] HEADER_BYTE   = DEFAULT_HEADER_BYTE
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  input  logic [31:0] pc_in,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [5:0] LAST_IDX    = 6'(NUM_REGS - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  dump_state_e state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [3:0]  settle_q, settle_d;
  logic [7:0]  csum_q, csum_d;
  logic [4:0]  reg_sel_q, reg_sel_d;
  logic        tx_valid_q, tx_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        sh_load_s, sh_shift_s, sh_last_s;
  logic [31:0] sh_word_s;
  logic [1:0]  sh_len_s;
  logic [7:0]  sh_byte_s;
  logic        xfer_s;

`ifdef DUMP_PC_HEADER_EN
  logic [31:0] pc_q, pc_d;
`else
  logic        unused_pc_s;
  assign unused_pc_s = ^pc_in;
`endif

  assign xfer_s = tx_valid_q && tx_ready;

  // Frame sequencing: next state, index/settle counters, checksum and output flags.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    settle_d   = settle_q;
    csum_d     = csum_q;
    reg_sel_d  = reg_sel_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sh_load_s  = 1'b0;
    sh_shift_s = 1'b0;
    sh_word_s  = 32'h0000_0000;
    sh_len_s   = 2'd0;
`ifdef DUMP_PC_HEADER_EN
    pc_d       = pc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        reg_sel_d = 5'd0;
        if (start) begin
          state_d    = ST_HDR;
          busy_d     = 1'b1;
          csum_d     = 8'h00;
          tx_valid_d = 1'b1;
          sh_load_s  = 1'b1;
          sh_word_s  = {HEADER_BYTE, 24'h00_0000};
`ifdef DUMP_PC_HEADER_EN
          pc_d       = pc_in;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (xfer_s) begin
`ifdef DUMP_PC_HEADER_EN
          state_d   = ST_PCB;
          sh_load_s = 1'b1;
          sh_word_s = pc_q;
          sh_len_s  = 2'd3;
`else
          state_d    = ST_SEL;
          tx_valid_d = 1'b0;
          idx_d      = 6'd0;
          reg_sel_d  = 5'd0;
          settle_d   = 4'd0;
`endif
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_PCB: begin
        if (xfer_s) begin
          csum_d = csum_q ^ sh_byte_s;
          if (sh_last_s) begin
            state_d    = ST_SEL;
            tx_valid_d = 1'b0;
            idx_d      = 6'd0;
            reg_sel_d  = 5'd0;
            settle_d   = 4'd0;
          end else begin
            sh_shift_s = 1'b1;
          end
        end else begin
          state_d = ST_PCB;
        end
      end
      ST_SEL: begin
        // reg_sel has been stable for the whole settle window when this fires.
        if (settle_q == SETTLE_LAST) begin
          state_d    = ST_BYTE;
          tx_valid_d = 1'b1;
          sh_load_s  = 1'b1;
          sh_word_s  = reg_data;
          sh_len_s   = 2'd3;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      ST_BYTE: begin
        if (xfer_s) begin
          csum_d = csum_q ^ sh_byte_s;
          if (!sh_last_s) begin
            sh_shift_s = 1'b1;
          end else if (idx_q == LAST_IDX) begin
            state_d   = ST_CSUM;
            sh_load_s = 1'b1;
            sh_word_s = {csum_d, 24'h00_0000};
          end else begin
            state_d    = ST_SEL;
            tx_valid_d = 1'b0;
            idx_d      = idx_q + 6'd1;
            reg_sel_d  = 5'(idx_q + 6'd1);
            settle_d   = 4'd0;
          end
        end else begin
          state_d = ST_BYTE;
        end
      end
      ST_CSUM: begin
        if (xfer_s) begin
          state_d    = ST_FIN;
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          reg_sel_d  = 5'd0;
        end else begin
          state_d = ST_CSUM;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        reg_sel_d  = 5'd0;
      end
    endcase
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      idx_q      <= 6'd0;
      settle_q   <= 4'd0;
      csum_q     <= 8'h00;
      reg_sel_q  <= 5'd0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef DUMP_PC_HEADER_EN
      pc_q       <= 32'h0000_0000;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      settle_q   <= settle_d;
      csum_q     <= csum_d;
      reg_sel_q  <= reg_sel_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef DUMP_PC_HEADER_EN
      pc_q       <= pc_d;
`endif
    end
  end

  dump_byte_shifter u_shifter (
    .clk       (clk),
    .rstn      (rstn),
    .load      (sh_load_s),
    .load_word (sh_word_s),
    .load_len  (sh_len_s),
    .shift     (sh_shift_s),
    .byte_out  (sh_byte_s),
    .last      (sh_last_s)
  );

  assign reg_sel  = reg_sel_q;
  assign tx_data  = sh_byte_s;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_regfile_dump_scanner.sv
// Scoreboard bench for regfile_dump_scanner: expected frames are queued at start,
// negedge monitors pop and compare every accepted byte. Honours DUMP_PC_HEADER_EN.
module tb_regfile_dump_scanner;
  import regfile_dump_scanner_pkg::*;

  localparam int NREG = 32;
`ifdef DUMP_PC_HEADER_EN
  localparam bit         PC_EN    = 1'b1;
  localparam logic [7:0] EXP_CSUM = 8'hD4;  // 31 x 0x10, indices 1..31 cancel, ^ 0xC4
`else
  localparam bit         PC_EN    = 1'b0;
  localparam logic [7:0] EXP_CSUM = 8'h10;  // 31 x 0x10, indices 1..31 cancel
`endif
  localparam logic [31:0] PC_VAL  = 32'h0000_00C4;
  localparam int FRAME_LEN = frame_bytes(NREG, PC_EN);
  localparam int CYC_A = 2 + NREG * (1 + 4) - 1 + (PC_EN ? 4 : 0);
  localparam int CYC_B = 2 + NREG * (3 + 4) - 1 + (PC_EN ? 4 : 0);

  typedef struct packed {
    logic [7:0] data;
    logic       chk_sel;
    logic [4:0] sel;
  } exp_t;
  typedef exp_t exp_list_t[$];

  logic clk = 1'b0;
  logic rstn, tx_ready, rand_ready;
  logic start_a, tx_valid_a, busy_a, done_a;
  logic start_b, tx_valid_b, busy_b, done_b;
  logic [4:0]  reg_sel_a, reg_sel_b;
  logic [4:0]  sel_b_p1 = 5'd0, sel_b_p2 = 5'd0;
  logic [31:0] reg_data_a, reg_data_b;
  logic [7:0]  tx_data_a, tx_data_b;
  logic [31:0] pc_in = PC_VAL;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int bytes_a = 0, bytes_b = 0, done_cnt_a = 0, done_cnt_b = 0;
  int hdr_cyc_a = 0, end_cyc_a = 0, hdr_cyc_b = 0, end_cyc_b = 0;
  exp_list_t exp_a, exp_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT B sees reg_data two cycles after reg_sel changes.
  always @(posedge clk) begin
    sel_b_p1 <= reg_sel_b;
    sel_b_p2 <= sel_b_p1;
  end

  assign reg_data_a = (reg_sel_a == 5'd0) ? 32'h0 : 32'h1000_0000 + {27'h0, reg_sel_a};
  assign reg_data_b = (sel_b_p2 == 5'd0) ? 32'h0 : 32'h1000_0000 + {27'h0, sel_b_p2};

  regfile_dump_scanner #(.NUM_REGS(NREG), .SETTLE_CYCLES(1), .HEADER_BYTE(8'hA5)) dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .reg_sel(reg_sel_a), .reg_data(reg_data_a),
    .pc_in(pc_in), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready),
    .busy(busy_a), .done(done_a));

  regfile_dump_scanner #(.NUM_REGS(NREG), .SETTLE_CYCLES(3), .HEADER_BYTE(8'hA5)) dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .reg_sel(reg_sel_b), .reg_data(reg_data_b),
    .pc_in(pc_in), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready),
    .busy(busy_b), .done(done_b));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Hand-listed frame: A5, [PC], 00000000, 10000001 .. 1000001F, checksum.
  function automatic exp_list_t make_frame();
    exp_list_t f;
    logic [31:0] w;
    f.push_back('{data: 8'hA5, chk_sel: 1'b0, sel: 5'd0});
    if (PC_EN) begin
      w = PC_VAL;
      for (int b = 3; b >= 0; b--) f.push_back('{data: w[b*8 +: 8], chk_sel: 1'b0, sel: 5'd0});
    end
    for (int r = 0; r < NREG; r++) begin
      w = (r == 0) ? 32'h0 : 32'h1000_0000 + 32'(r);
      for (int b = 3; b >= 0; b--) f.push_back('{data: w[b*8 +: 8], chk_sel: 1'b1, sel: 5'(r)});
    end
    f.push_back('{data: EXP_CSUM, chk_sel: 1'b0, sel: 5'd0});
    return f;
  endfunction

  // Monitor for DUT A: byte order, reg_sel during BYTE, hold under stall, done pulses.
  initial begin : mon_a
    logic stall;
    logic [7:0] held;
    exp_t e;
    stall = 1'b0;
    held = 8'h00;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("a_hold_valid", tx_valid_a, 1);
          check("a_hold_data", tx_data_a, held);
        end
        if (tx_valid_a && tx_ready) begin
          if (exp_a.size() == 0) begin
            check("a_extra_byte", tx_data_a, 32'hFFFF_FFFF);
          end else begin
            e = exp_a.pop_front();
            if (bytes_a == 0) hdr_cyc_a = cyc;
            check($sformatf("a_byte%0d", bytes_a), tx_data_a, e.data);
            if (e.chk_sel) check($sformatf("a_sel%0d", bytes_a), reg_sel_a, e.sel);
            bytes_a++;
            if (exp_a.size() == 0) end_cyc_a = cyc;
          end
        end
        if (done_a) done_cnt_a++;
        stall = tx_valid_a && !tx_ready;
        held = tx_data_a;
      end
    end
  end

  // Monitor for DUT B (slow settle, delayed reg_data).
  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && tx_valid_b && tx_ready) begin
        if (exp_b.size() == 0) begin
          check("b_extra_byte", tx_data_b, 32'hFFFF_FFFF);
        end else begin
          e = exp_b.pop_front();
          if (bytes_b == 0) hdr_cyc_b = cyc;
          check($sformatf("b_byte%0d", bytes_b), tx_data_b, e.data);
          if (e.chk_sel) check($sformatf("b_sel%0d", bytes_b), reg_sel_b, e.sel);
          bytes_b++;
          if (exp_b.size() == 0) end_cyc_b = cyc;
        end
      end
      if (rstn && done_b) done_cnt_b++;
    end
  end

  // Ready driver: fixed high, or roughly 30% duty.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  task automatic pulse_start(input bit use_b);
    @(posedge clk);
    #1;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Bounded wait for done; optionally spams start on A while busy; then frame checks.
  task automatic run_frame(input bit use_b, input string tag, input int budget,
                           input bit spam, input bit chk_cyc);
    int d0, i;
    if (use_b) begin bytes_b = 0; exp_b = make_frame(); end
    else begin bytes_a = 0; exp_a = make_frame(); end
    pulse_start(use_b);
    d0 = use_b ? done_cnt_b : done_cnt_a;
    i = 0;
    while ((use_b ? done_cnt_b : done_cnt_a) == d0 && i < budget) begin
      @(posedge clk);
      #1;
      start_a = spam && busy_a && (i % 4 == 0);
      i++;
    end
    start_a = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check({tag, "_done_pulses"}, (use_b ? done_cnt_b : done_cnt_a) - d0, 1);
    check({tag, "_busy_after"}, use_b ? busy_b : busy_a, 0);
    check({tag, "_bytes"}, use_b ? bytes_b : bytes_a, FRAME_LEN);
    check({tag, "_queue_left"}, use_b ? exp_b.size() : exp_a.size(), 0);
    if (chk_cyc) begin
      if (use_b) check({tag, "_cycles"}, end_cyc_b - hdr_cyc_b, CYC_B);
      else       check({tag, "_cycles"}, end_cyc_a - hdr_cyc_a, CYC_A);
    end
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int i;
    rstn = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    rand_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", tx_valid_a, 0);
    check("rst_tx_data", tx_data_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_reg_sel", reg_sel_a, 0);
    check("rst_b_tx_valid", tx_valid_b, 0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    run_frame(1'b0, "ready_hi", 400, 1'b0, 1'b1);

    rand_ready = 1'b1;
    run_frame(1'b0, "ready_rand", 3000, 1'b0, 1'b0);
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);

    run_frame(1'b0, "start_spam", 400, 1'b1, 1'b1);

    // Reset after the 50th accepted byte aborts the frame at once.
    bytes_a = 0;
    exp_a = make_frame();
    pulse_start(1'b0);
    i = 0;
    while (bytes_a < 50 && i < 300) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("abort_reached_50", bytes_a, 50);
    rstn = 1'b0;
    #1;
    check("abort_tx_valid", tx_valid_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_reg_sel", reg_sel_a, 0);
    exp_a.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    run_frame(1'b0, "after_abort", 400, 1'b0, 1'b1);

    run_frame(1'b1, "settle3", 600, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
